uart_rx_byte: RTL and testbench

//   8N1 UART receiver. It is the consumer stage for the serial line that our

---
 rtl/uart_rx_byte.sv | 199 +++++++++++++++++++
 tb/tb_uart_rx_byte.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_byte.sv
// ---------------------------------------------------------------------------
// uart_rx_byte
//   8N1 UART receiver. Synchronises the asynchronous rx pin, qualifies the
//   start bit at its centre, samples each data bit at its centre (LSB first),
//   checks the stop bit and hands each byte downstream on a valid/ready pair.
//   Framing errors and overruns are reported as single-cycle pulses.
//
// Parameters
//   CLKS_PER_BIT  clk cycles per serial bit (>= 4)
//
// Ports
//   clk        in   1  system clock, rising edge
//   rst        in   1  synchronous, active-high reset
//   rx         in   1  asynchronous serial input, idle high
//   rx_data    out  8  received byte, held while rx_valid && !rx_ready
//   rx_valid   out  1  rx_data holds an unconsumed byte
//   rx_ready   in   1  consumer accepts rx_data when rx_valid is high
//   frame_err  out  1  one-cycle pulse: stop bit sampled low
//   overrun    out  1  one-cycle pulse: byte dropped, previous one unconsumed
// ---------------------------------------------------------------------------
module uart_rx_byte #(
    parameter int unsigned CLKS_PER_BIT = 1302
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam int unsigned Half = CLKS_PER_BIT / 2;
    localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] HalfLast = CntW'(Half - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } state_e;

    // Two-flop synchroniser; reset high so reset never looks like a start bit.
    logic rx_meta_q;
    logic rxs_q;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shreg_q, shreg_d;

    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       frame_err_q, frame_err_d;
    logic       overrun_q, overrun_d;

    logic byte_done;
    logic stop_bad;
    logic handshake;

    // -----------------------------------------------------------------------
    // Receive FSM: next state
    // -----------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        byte_done = 1'b0;
        stop_bad  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!rxs_q) begin
                    state_d = StStart;
                    cnt_d   = '0;
                end
            end

            // Re-check the line half a bit in; a high level means a glitch.
            StStart: begin
                if (cnt_q == HalfLast) begin
                    cnt_d = '0;
                    if (rxs_q) begin
                        state_d = StIdle;
                    end else begin
                        state_d   = StData;
                        bit_idx_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            // Right shift so the first (LSB) bit ends up in shreg[0].
            StData: begin
                if (cnt_q == BitLast) begin
                    cnt_d     = '0;
                    shreg_d   = {rxs_q, shreg_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = StStop;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            StStop: begin
                if (cnt_q == BitLast) begin
                    cnt_d = '0;
                    if (rxs_q) begin
                        byte_done = 1'b1;
                        state_d   = StIdle;
                    end else begin
                        stop_bad = 1'b1;
                        state_d  = StBreak;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            // Hold off until the line idles so a long low is not re-read as data.
            StBreak: begin
                if (rxs_q) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Output holding register and error pulses
    // -----------------------------------------------------------------------
    assign handshake = rx_valid_q && rx_ready;

    always_comb begin
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        frame_err_d = stop_bad;
        overrun_d   = 1'b0;

        if (byte_done) begin
            // A consume in the same cycle frees the slot for the new byte.
            if (!rx_valid_q || handshake) begin
                rx_data_d  = shreg_q;
                rx_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (handshake) begin
            rx_valid_d = 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q   <= 1'b1;
            rxs_q       <= 1'b1;
            state_q     <= StIdle;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shreg_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            rx_meta_q   <= rx;
            rxs_q       <= rx_meta_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shreg_q     <= shreg_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_byte.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_byte
//   Self-checking bench for uart_rx_byte. A frame-level model predicts, for
//   each frame the bench sends, the clock edge at which the byte completes
//   (start edge + 3 + HALF + 9*CLKS_PER_BIT) and applies the valid/ready and
//   error rules there. Outputs are compared against the model on every
//   falling edge; directed literal checks pin the model to hand values.
// ---------------------------------------------------------------------------
module tb_uart_rx_byte;

    localparam int unsigned CPB      = 37;
    localparam int unsigned HALF     = CPB / 2;            // 18
    localparam int unsigned DONE_OFS = 3 + HALF + 9 * CPB; // 354

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;

    uart_rx_byte #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned edge_no;
        logic [7:0]  data;
        logic        ok;
    } frame_t;

    frame_t      q[$];
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    logic       m_valid = 1'b0;
    logic [7:0] m_data = 8'h00;
    logic       exp_ferr = 1'b0;
    logic       exp_ovr = 1'b0;
    bit         chk_en = 1'b0;

    int   ovr_cnt = 0;
    int   ferr_cnt = 0;
    int   deliv_cnt = 0;
    logic prev_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, want 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Model: advances on every rising edge using the inputs seen at that edge.
    always @(posedge clk) begin : model
        frame_t ev;
        logic   hs;
        cyc++;
        exp_ferr = 1'b0;
        exp_ovr  = 1'b0;
        hs = m_valid && rx_ready;
        if (rst) begin
            chk_en  = 1'b1;
            m_valid = 1'b0;
            m_data  = 8'h00;
            q.delete();
        end else if (q.size() != 0 && q[0].edge_no == cyc) begin
            ev = q.pop_front();
            if (!ev.ok) begin
                exp_ferr = 1'b1;
            end else if (!m_valid || hs) begin
                m_data  = ev.data;
                m_valid = 1'b1;
            end else begin
                exp_ovr = 1'b1;
            end
        end else if (hs) begin
            m_valid = 1'b0;
        end
    end

    // Compare process, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("rx_valid", 32'(rx_valid), 32'(m_valid));
            check("rx_data", 32'(rx_data), 32'(m_data));
            check("frame_err", 32'(frame_err), 32'(exp_ferr));
            check("overrun", 32'(overrun), 32'(exp_ovr));
            if (overrun === 1'b1) ovr_cnt++;
            if (frame_err === 1'b1) ferr_cnt++;
            if (rx_valid === 1'b1 && prev_valid !== 1'b1) deliv_cnt++;
            prev_valid = rx_valid;
        end
    end

    // Advance n rising edges, then step just past the edge.
    task automatic step(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one frame starting now; stop level held for stop_len cycles.
    task automatic send_frame(input logic [7:0] d, input logic stop_val,
                              input int unsigned stop_len);
        frame_t ev;
        ev.edge_no = cyc + DONE_OFS;
        ev.data    = d;
        ev.ok      = stop_val;
        q.push_back(ev);
        rx = 1'b0;
        step(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            step(CPB);
        end
        rx = stop_val;
        step(stop_len);
        rx = 1'b1;
    endtask

    initial begin
        int d0;
        rst      = 1'b1;
        rx       = 1'b1;
        rx_ready = 1'b0;
        step(4);
        check("reset_valid", 32'(rx_valid), 32'd0);
        check("reset_data", 32'(rx_data), 32'd0);
        check("reset_flags", 32'({frame_err, overrun}), 32'd0);
        rst = 1'b0;
        step(10);

        // 1: 0x4A with exact completion timing, then a minimum-gap 0xC3.
        rx_ready = 1'b1;
        fork
            send_frame(8'h4A, 1'b1, HALF + 1);
            begin
                step(DONE_OFS - 1);
                check("t1_before_done", 32'(rx_valid), 32'd0);
                step(1);
                check("t1_valid", 32'(rx_valid), 32'd1);
                check("t1_data", 32'(rx_data), 32'h4A);
                check("t1_model_data", 32'(m_data), 32'h4A);
            end
        join
        send_frame(8'hC3, 1'b1, CPB);
        step(20);
        check("t1_b2b_data", 32'(rx_data), 32'hC3);
        check("t1_deliveries", 32'(deliv_cnt), 32'd2);

        // 2: short low glitch, then a good 0x55.
        rx = 1'b0;
        step(HALF - 2);
        rx = 1'b1;
        step(3 * CPB);
        check("t2_glitch_deliv", 32'(deliv_cnt), 32'd2);
        check("t2_glitch_ferr", 32'(ferr_cnt), 32'd0);
        send_frame(8'h55, 1'b1, CPB);
        step(20);
        check("t2_data", 32'(rx_data), 32'h55);
        check("t2_deliveries", 32'(deliv_cnt), 32'd3);

        // 3: 0xA5 with a low stop bit held for three bit times.
        send_frame(8'hA5, 1'b0, 3 * CPB);
        step(3 * CPB);
        check("t3_ferr_count", 32'(ferr_cnt), 32'd1);
        check("t3_deliveries", 32'(deliv_cnt), 32'd3);

        // 4: overrun while 0x11 is unconsumed.
        rx_ready = 1'b0;
        send_frame(8'h11, 1'b1, CPB);
        step(5);
        check("t4_first_valid", 32'(rx_valid), 32'd1);
        check("t4_first_data", 32'(rx_data), 32'h11);
        send_frame(8'h22, 1'b1, CPB);
        step(5);
        check("t4_kept_data", 32'(rx_data), 32'h11);
        check("t4_ovr_count", 32'(ovr_cnt), 32'd1);
        rx_ready = 1'b1;
        step(1);
        check("t4_drained", 32'(rx_valid), 32'd0);

        // 5: consume in the exact completion cycle of 0x33 with 0x22 pending.
        rx_ready = 1'b0;
        send_frame(8'h22, 1'b1, CPB);
        step(5);
        fork
            send_frame(8'h33, 1'b1, CPB);
            begin
                step(DONE_OFS - 1);
                rx_ready = 1'b1;
                step(1);
                rx_ready = 1'b0;
            end
        join
        step(5);
        check("t5_data", 32'(rx_data), 32'h33);
        check("t5_valid", 32'(rx_valid), 32'd1);
        check("t5_ovr_count", 32'(ovr_cnt), 32'd1);
        rx_ready = 1'b1;
        step(3);

        // 6: reset during data bit 4 of 0xFF, then 0x0F.
        d0 = deliv_cnt;
        rx = 1'b0;
        step(CPB);
        rx = 1'b1;
        step(4 * CPB + HALF);
        rst = 1'b1;
        step(1);
        check("t6_rst_valid", 32'(rx_valid), 32'd0);
        check("t6_rst_data", 32'(rx_data), 32'd0);
        step(4);
        rst = 1'b0;
        step(3 * CPB);
        send_frame(8'h0F, 1'b1, CPB);
        step(20);
        check("t6_data", 32'(rx_data), 32'h0F);
        check("t6_deliveries", 32'(deliv_cnt - d0), 32'd1);
        check("t6_ferr_count", 32'(ferr_cnt), 32'd1);

        step(10);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
